btn_step_ctrl: RTL and testbench

Parametrised front-panel controller: synchronises and individually debounces N_BTN push-buttons, then drives N_CH signed, saturating offset registers with hold-to-repeat and acceleration, a clear function, and a volume-step counter. Sits between the board buttons/switches and the FM synth's frequency-control words, and is the generalised successor of the current button controller.

---
 rtl/btn_step_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_btn_step_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_step_ctrl.sv
// Front-panel controller: per-button sync + debounce, hold-to-repeat offset stepping
// with acceleration and saturation, clear, and a volume-step counter.
module btn_step_ctrl #(
  parameter int N_BTN       = 4,
  parameter int DB_CYCLES   = 100_000,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int RPT_CYCLES  = 524_288,
  parameter int FAST_AFTER  = 8,
  parameter int N_CH        = 2,
  parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int OFS_W       = 32,
  parameter int VOL_W       = 2,
  parameter int VOL_WRAP    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_BTN-1:0]      btn,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic [OFS_W-1:0]      step,
  output logic [N_BTN-1:0]      btn_level,
  output logic [N_BTN-1:0]      btn_press,
  output logic [N_CH*OFS_W-1:0] offsets,
  output logic [VOL_W-1:0]      vol_step,
  output logic [1:0]            fsm_state
);

  localparam int DB_W    = $clog2(DB_CYCLES + 1);
  localparam int CYC_MAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int RC_W    = $clog2(FAST_AFTER + 1);
  localparam int SW      = OFS_W + 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [1:0] ST_FAST   = 2'd3;

  logic [N_BTN-1:0] sync1, sync2;
  logic [DB_W-1:0]  db_cnt [N_BTN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // A level change is accepted only after DB_CYCLES+1 consecutive mismatching samples,
  // so the press lands 2+DB_CYCLES edges after the raw edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_level <= '0;
      btn_press <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        btn_press[i] <= 1'b0;
        if (sync2[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DB_CYCLES)) begin
          db_cnt[i]    <= '0;
          btn_level[i] <= ~btn_level[i];
          btn_press[i] <= ~btn_level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [1:0]       state;
  logic             dir_dn;
  logic [CYC_W-1:0] cyc_cnt;
  logic [RC_W-1:0]  rpt_cnt;
  logic             dir_level, abort, go_up, go_dn;
  logic             hold_hit, rpt_hit, step_fire, step_x4, step_dn;

  always_comb begin
    dir_level = dir_dn ? btn_level[1] : btn_level[0];
    abort     = btn_level[3] | (btn_level[0] & btn_level[1]) | ~dir_level;
    go_up     = btn_press[0] & ~btn_level[1] & ~btn_level[3];
    go_dn     = btn_press[1] & ~btn_level[0] & ~btn_level[3];
    hold_hit  = (cyc_cnt == CYC_W'(HOLD_CYCLES - 1));
    rpt_hit   = (cyc_cnt == CYC_W'(RPT_CYCLES - 1));
    step_fire = 1'b0;
    step_x4   = 1'b0;
    step_dn   = dir_dn;
    case (state)
      ST_IDLE: begin
        step_fire = go_up | go_dn;
        step_dn   = go_dn;
      end
      ST_HOLD:   step_fire = ~abort & hold_hit;
      ST_REPEAT: step_fire = ~abort & rpt_hit;
      default: begin
        step_fire = ~abort & rpt_hit;
        step_x4   = 1'b1;
      end
    endcase
  end

  // The step leaving HOLD counts as the first repeat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      dir_dn  <= 1'b0;
      cyc_cnt <= '0;
      rpt_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go_up | go_dn) begin
            state   <= ST_HOLD;
            dir_dn  <= go_dn;
            cyc_cnt <= '0;
            rpt_cnt <= '0;
          end
        end
        default: begin
          if (abort) begin
            state   <= ST_IDLE;
            cyc_cnt <= '0;
            rpt_cnt <= '0;
          end else if (step_fire) begin
            cyc_cnt <= '0;
            if (state == ST_HOLD) begin
              rpt_cnt <= RC_W'(1);
              state   <= (FAST_AFTER <= 1) ? ST_FAST : ST_REPEAT;
            end else if (state == ST_REPEAT) begin
              rpt_cnt <= rpt_cnt + 1'b1;
              if (rpt_cnt == RC_W'(FAST_AFTER - 1)) state <= ST_FAST;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign fsm_state = state;

  logic [OFS_W-1:0] ofs_q [N_CH];
  logic [SW-1:0]    mag, delta;
  logic [SW-1:0]    sum [N_CH];
  logic [OFS_W-1:0] sat [N_CH];

  // Sum in OFS_W+3 bits; any disagreement among the top four bits means overflow.
  always_comb begin
    mag = {3'b000, step};
    if (step_x4) mag = mag << 2;
    delta = step_dn ? (~mag + 1'b1) : mag;
    for (int k = 0; k < N_CH; k++) begin
      sum[k] = {{3{ofs_q[k][OFS_W-1]}}, ofs_q[k]} + delta;
      if (sum[k][SW-1:OFS_W-1] == '0 || sum[k][SW-1:OFS_W-1] == '1)
        sat[k] = sum[k][OFS_W-1:0];
      else if (sum[k][SW-1])
        sat[k] = {1'b1, {(OFS_W-1){1'b0}}};
      else
        sat[k] = {1'b0, {(OFS_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) ofs_q[k] <= '0;
    end else if (btn_level[3]) begin
      for (int k = 0; k < N_CH; k++) ofs_q[k] <= '0;
    end else if (step_fire) begin
      for (int k = 0; k < N_CH; k++)
        if (ch_sel == CH_W'(k)) ofs_q[k] <= sat[k];
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_pack
    assign offsets[k*OFS_W +: OFS_W] = ofs_q[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vol_step <= '0;
    end else if (btn_press[2]) begin
      if (VOL_WRAP != 0 || vol_step != '1) vol_step <= vol_step + 1'b1;
    end
  end

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Bench for btn_step_ctrl: a 32-bit/2-channel wrapping instance and an 8-bit/3-channel
// saturating instance, both with short debounce/hold/repeat timings.
module tb_btn_step_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  btn_a, btn_b;
  logic        ch_sel_a;
  logic [1:0]  ch_sel_b;
  logic [31:0] step_a;
  logic [7:0]  step_b;
  logic [3:0]  a_level, a_press, b_level, b_press;
  logic [63:0] a_offsets;
  logic [23:0] b_offsets;
  logic [1:0]  a_vol, b_vol, a_state, b_state;

  always #5 clk = ~clk;

  btn_step_ctrl #(
    .N_BTN(4), .DB_CYCLES(4), .HOLD_CYCLES(20), .RPT_CYCLES(5), .FAST_AFTER(8),
    .N_CH(2), .OFS_W(32), .VOL_W(2), .VOL_WRAP(1)
  ) dut_a (
    .clk(clk), .reset(reset), .btn(btn_a), .ch_sel(ch_sel_a), .step(step_a),
    .btn_level(a_level), .btn_press(a_press), .offsets(a_offsets),
    .vol_step(a_vol), .fsm_state(a_state)
  );

  btn_step_ctrl #(
    .N_BTN(4), .DB_CYCLES(4), .HOLD_CYCLES(20), .RPT_CYCLES(5), .FAST_AFTER(8),
    .N_CH(3), .OFS_W(8), .VOL_W(2), .VOL_WRAP(0)
  ) dut_b (
    .clk(clk), .reset(reset), .btn(btn_b), .ch_sel(ch_sel_b), .step(step_b),
    .btn_level(b_level), .btn_press(b_press), .offsets(b_offsets),
    .vol_step(b_vol), .fsm_state(b_state)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int a_ch(input int k);
    return $signed(a_offsets[k*32 +: 32]);
  endfunction

  function automatic int b_ch(input int k);
    return int'($signed(b_offsets[k*8 +: 8]));
  endfunction

  // Scoreboard for channel 0 of dut_a: value and cycle of each change.
  logic [31:0] exp_q[$];
  int          exp_t_q[$];
  bit          mon_en = 1'b0;
  int          prev_ch0 = 0;

  always @(negedge clk) begin
    if (mon_en && a_ch(0) != prev_ch0) begin
      if (exp_q.size() == 0) begin
        check("ch0_unexpected_change", a_ch(0), prev_ch0);
      end else begin
        check("ch0_value", a_ch(0), $signed(exp_q.pop_front()));
        check("ch0_time", cyc, exp_t_q.pop_front());
      end
    end
    prev_ch0 = a_ch(0);
  end

  // Volume scoreboards: compared one cycle after each volume press.
  logic [1:0] vol_qa[$], vol_qb[$];
  bit         pa_d = 1'b0, pb_d = 1'b0;

  always @(negedge clk) begin
    if (pa_d) begin
      if (vol_qa.size() == 0) check("vol_a_unexpected", a_vol, -1);
      else check("vol_a", a_vol, vol_qa.pop_front());
    end
    if (pb_d) begin
      if (vol_qb.size() == 0) check("vol_b_unexpected", b_vol, -1);
      else check("vol_b", b_vol, vol_qb.pop_front());
    end
    pa_d = a_press[2];
    pb_d = b_press[2];
  end

  int pcnt_b[4];
  initial for (int i = 0; i < 4; i++) pcnt_b[i] = 0;
  always @(negedge clk)
    for (int i = 0; i < 4; i++) if (b_press[i]) pcnt_b[i]++;

  typedef struct {
    int idx; int len; int sel; int press; int e0; int e1; int e2;
  } vec_t;
  vec_t tbl[8];

  task automatic tap_a(input int idx, input int sel);
    ch_sel_a = sel[0];
    btn_a[idx] = 1'b1;
    repeat (10) @(negedge clk);
    btn_a[idx] = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  initial begin
    int t, t0, got, v, nz, base, vm_a, vm_b, prev_b1, wrap_viol;

    btn_a = '0; btn_b = '0; ch_sel_a = 1'b0; ch_sel_b = 2'd0;
    step_a = 32'd20; step_b = 8'd20;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_offsets_a", a_offsets, 0);
    check("rst_offsets_b", b_offsets, 0);
    check("rst_level", {a_level, b_level}, 0);
    check("rst_press", {a_press, b_press}, 0);
    check("rst_vol", {a_vol, b_vol}, 0);
    check("rst_state", {a_state, b_state}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Hold up on dut_a: single step, hold repeat, normal repeats, fast repeats, release.
    t = cyc + 1;
    btn_a[0] = 1'b1;
    mon_en = 1'b1;
    v = 0;
    for (int k = 0; k < 12; k++) begin
      v += (k >= 9) ? 80 : 20;
      exp_q.push_back(32'(v));
      exp_t_q.push_back((k == 0) ? t + 7 : t + 27 + 5 * (k - 1));
    end
    repeat (73) @(negedge clk);
    btn_a[0] = 1'b0;
    repeat (30) @(negedge clk);
    mon_en = 1'b0;
    check("ch0_sb_empty", exp_q.size(), 0);
    check("ch0_after_release", a_ch(0), 420);
    check("state_idle_after_release", a_state, 0);

    // Reset in the middle of FAST with the button still held.
    btn_a[0] = 1'b1;
    repeat (70) @(negedge clk);
    check("state_fast", a_state, 3);
    #1 reset = 1'b1;
    #1;
    check("async_rst_offsets", a_offsets, 0);
    check("async_rst_level", a_level, 0);
    check("async_rst_press", a_press, 0);
    check("async_rst_state", a_state, 0);
    @(negedge clk);
    reset = 1'b0;
    t0 = cyc + 1;
    got = -1;
    for (int n = 0; n < 20 && got < 0; n++) begin
      @(negedge clk);
      if (a_press[0]) got = cyc - t0;
    end
    check("press_latency_after_reset", got, 6);
    @(negedge clk);
    check("ch0_after_reset_press", a_ch(0), 20);
    btn_a[0] = 1'b0;
    repeat (15) @(negedge clk);

    // Clear priority: set ch0=60, ch1=-40 then hold clear together with up.
    tap_a(0, 0);
    tap_a(0, 0);
    tap_a(1, 1);
    tap_a(1, 1);
    check("pre_clear_ch0", a_ch(0), 60);
    check("pre_clear_ch1", a_ch(1), -40);
    ch_sel_a = 1'b0;
    btn_a[3] = 1'b1;
    btn_a[0] = 1'b1;
    repeat (7) @(negedge clk);
    check("clear_level", a_level[3], 1);
    check("clear_ch0_not_yet", a_ch(0), 60);
    @(negedge clk);
    check("clear_ch0", a_ch(0), 0);
    check("clear_ch1", a_ch(1), 0);
    nz = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_offsets != 64'd0) nz++;
    end
    check("clear_hold_zero_cycles", nz, 0);
    btn_a[3] = 1'b0;
    repeat (15) @(negedge clk);
    check("post_clear_offsets", a_offsets, 0);
    check("post_clear_state", a_state, 0);
    btn_a[0] = 1'b0;
    repeat (15) @(negedge clk);

    // Volume on both instances: dut_a wraps, dut_b saturates.
    vm_a = 0;
    vm_b = 0;
    for (int k = 0; k < 5; k++) begin
      vm_a = (vm_a + 1) % 4;
      vm_b = (vm_b == 3) ? 3 : vm_b + 1;
      vol_qa.push_back(2'(vm_a));
      vol_qb.push_back(2'(vm_b));
      btn_a[2] = 1'b1;
      btn_b[2] = 1'b1;
      repeat (10) @(negedge clk);
      btn_a[2] = 1'b0;
      btn_b[2] = 1'b0;
      repeat (12) @(negedge clk);
    end
    check("vol_qa_empty", vol_qa.size(), 0);
    check("vol_qb_empty", vol_qb.size(), 0);
    check("vol_a_final", a_vol, 1);
    check("vol_b_final", b_vol, 3);

    // Debounce and channel select vectors on dut_b.
    tbl[0] = '{0, 3, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 4, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 10, 0, 1, 20, 0, 0};
    tbl[3] = '{0, 5, 0, 1, 40, 0, 0};
    tbl[4] = '{0, 10, 3, 1, 40, 0, 0};
    tbl[5] = '{0, 10, 2, 1, 40, 0, 20};
    tbl[6] = '{1, 10, 0, 1, 20, 0, 20};
    tbl[7] = '{1, 10, 2, 1, 20, 0, 0};
    for (int i = 0; i < 8; i++) begin
      base = pcnt_b[tbl[i].idx];
      ch_sel_b = 2'(tbl[i].sel);
      btn_b[tbl[i].idx] = 1'b1;
      repeat (tbl[i].len) @(negedge clk);
      btn_b[tbl[i].idx] = 1'b0;
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d_presses", i), pcnt_b[tbl[i].idx] - base, tbl[i].press);
      check($sformatf("vec%0d_ch0", i), b_ch(0), tbl[i].e0);
      check($sformatf("vec%0d_ch1", i), b_ch(1), tbl[i].e1);
      check($sformatf("vec%0d_ch2", i), b_ch(2), tbl[i].e2);
    end

    // Saturation: hold down on ch1 of the 8-bit instance.
    ch_sel_b = 2'd1;
    btn_b[1] = 1'b1;
    prev_b1 = b_ch(1);
    wrap_viol = 0;
    repeat (52) begin
      @(negedge clk);
      if (b_ch(1) > prev_b1) wrap_viol++;
      prev_b1 = b_ch(1);
    end
    check("sat_ch1_before_clamp", b_ch(1), -120);
    repeat (30) begin
      @(negedge clk);
      if (b_ch(1) > prev_b1) wrap_viol++;
      prev_b1 = b_ch(1);
    end
    check("sat_ch1_state_fast", b_state, 3);
    btn_b[1] = 1'b0;
    repeat (15) @(negedge clk);
    check("sat_ch1_clamped", b_ch(1), -128);
    check("sat_no_wrap", wrap_viol, 0);
    check("sat_ch0_untouched", b_ch(0), 20);
    check("sat_ch2_untouched", b_ch(2), 0);
    check("sat_level_released", b_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
